// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared definitions for the 6-stage pipeline sequencing controller.
//   ctrlState_t   : sequencing FSM states (RUN, LU_STALL, MEM_WAIT)
//   FWD_*         : EX-stage operand forwarding select encodings
//   PIPE_REG_AW   : default register-index width
package pipe_ctrl_pkg;

  localparam int unsigned PIPE_REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } ctrlState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M1 = 2'b01;
  localparam logic [1:0] FWD_M2 = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;

endpackage

// File: rtl/hazard_sched_ctrl_if.sv
// Bundle between the pipeline datapath and the sequencing controller.
//   Stage fields (datapath -> controller): ID sources/uses/jump, EX sources,
//   EX/M1/M2/WB destinations and write/read controls, data memory status.
//   Controls (controller -> datapath): stall_f, stall_d, flush_d, flush_e,
//   freeze, fwd_a_e, fwd_b_e, stall_cycles.
// master = datapath side, slave = controller side.
interface hazard_sched_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] rs_d, rt_d;
  logic              use_rs_d, use_rt_d, jump_d;
  logic [REG_AW-1:0] rs_e, rt_e, rd_e;
  logic              regwrite_e, memread_e;
  logic [REG_AW-1:0] rd_m1;
  logic              regwrite_m1, memread_m1;
  logic [REG_AW-1:0] rd_m2;
  logic              regwrite_m2;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_w;
  logic              dmem_req_m2, dmem_ready;

  logic              stall_f, stall_d, flush_d, flush_e, freeze;
  logic [1:0]        fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rs_d, rt_d, use_rs_d, use_rt_d, jump_d,
           rs_e, rt_e, rd_e, regwrite_e, memread_e,
           rd_m1, regwrite_m1, memread_m1, rd_m2, regwrite_m2,
           rd_w, regwrite_w, dmem_req_m2, dmem_ready,
    input  stall_f, stall_d, flush_d, flush_e, freeze,
           fwd_a_e, fwd_b_e, stall_cycles
  );

  modport slave (
    input  rs_d, rt_d, use_rs_d, use_rt_d, jump_d,
           rs_e, rt_e, rd_e, regwrite_e, memread_e,
           rd_m1, regwrite_m1, memread_m1, rd_m2, regwrite_m2,
           rd_w, regwrite_w, dmem_req_m2, dmem_ready,
    output stall_f, stall_d, flush_d, flush_e, freeze,
           fwd_a_e, fwd_b_e, stall_cycles
  );
endinterface

// File: rtl/hazard_sched_ctrl_fwd_sel.sv
// Per-operand EX forwarding select: M1 > M2 > WB > register file.
//   src    : EX source register index
//   m1Ok   : M1 result is forwardable (writes a reg and is not a load)
//   rdM1/rdM2/rdW, wrM2/wrW : later-stage destinations and RegWrite
//   sel    : FWD_RF / FWD_M1 / FWD_M2 / FWD_WB
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = PIPE_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              m1Ok,
  input  logic [REG_AW-1:0] rdM1,
  input  logic [REG_AW-1:0] rdM2,
  input  logic              wrM2,
  input  logic [REG_AW-1:0] rdW,
  input  logic              wrW,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (m1Ok && (rdM1 == src))      sel = FWD_M1;
      else if (wrM2 && (rdM2 == src)) sel = FWD_M2;
      else if (wrW && (rdW == src))   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Pipeline sequencing controller for the IF/ID/EX/M1/M2/WB core.
// Detects load-use hazards and inserts LU_PENALTY bubbles, freezes the pipe
// while data memory is busy, flushes IF/ID on jumps and drives EX forwarding.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : stage fields in, pipeline-register controls out (slave side)
module hazard_sched_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW     = PIPE_REG_AW,
  parameter int unsigned LU_PENALTY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_sched_ctrl_if.slave   bus
);

  localparam int unsigned LU_W = (LU_PENALTY > 1) ? $clog2(LU_PENALTY + 1) : 1;

  ctrlState_t        state, stateNext;
  logic [LU_W-1:0]   luCnt, luCntNext;
  logic [CNT_W-1:0]  stallCycles;
  logic              memBusy, hzE, hzM1, m1Ok;
  logic              stall, flushD, frz;
  logic [1:0]        fwdA, fwdB;

  always_comb begin
    memBusy = bus.dmem_req_m2 & ~bus.dmem_ready;
    hzE  = bus.memread_e & bus.regwrite_e & (bus.rd_e != '0) &
           ((bus.use_rs_d & (bus.rs_d == bus.rd_e)) |
            (bus.use_rt_d & (bus.rt_d == bus.rd_e)));
    hzM1 = bus.memread_m1 & bus.regwrite_m1 & (bus.rd_m1 != '0) &
           ((bus.use_rs_d & (bus.rs_d == bus.rd_m1)) |
            (bus.use_rt_d & (bus.rt_d == bus.rd_m1)));
    m1Ok = bus.regwrite_m1 & ~bus.memread_m1;
  end

  // luCnt counts bubbles still owed after the current one; it survives a
  // MEM_WAIT excursion so an interrupted stall resumes where it left off.
  always_comb begin
    stateNext = state;
    luCntNext = luCnt;
    stall     = 1'b0;
    flushD    = 1'b0;
    frz       = 1'b0;
    case (state)
      RUN: begin
        if (memBusy) begin
          frz       = 1'b1;
          stateNext = MEM_WAIT;
        end else if (hzE) begin
          stall     = 1'b1;
          luCntNext = LU_W'(LU_PENALTY - 1);
          stateNext = (LU_PENALTY > 1) ? LU_STALL : RUN;
        end else if (hzM1) begin
          stall = 1'b1;
        end else if (bus.jump_d) begin
          flushD = 1'b1;
        end
      end
      LU_STALL: begin
        if (memBusy) begin
          frz       = 1'b1;
          stateNext = MEM_WAIT;
        end else begin
          stall     = 1'b1;
          luCntNext = luCnt - 1'b1;
          if (luCnt <= LU_W'(1)) stateNext = RUN;
        end
      end
      MEM_WAIT: begin
        frz = 1'b1;
        if (bus.dmem_ready) stateNext = (luCnt != '0) ? LU_STALL : RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      luCnt       <= '0;
      stallCycles <= '0;
    end else begin
      state <= stateNext;
      luCnt <= luCntNext;
      if ((stall || frz) && (stallCycles != '1)) stallCycles <= stallCycles + 1'b1;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .src (bus.rs_e), .m1Ok(m1Ok),
    .rdM1(bus.rd_m1), .rdM2(bus.rd_m2), .wrM2(bus.regwrite_m2),
    .rdW (bus.rd_w),  .wrW (bus.regwrite_w),
    .sel (fwdA)
  );

  fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .src (bus.rt_e), .m1Ok(m1Ok),
    .rdM1(bus.rd_m1), .rdM2(bus.rd_m2), .wrM2(bus.regwrite_m2),
    .rdW (bus.rd_w),  .wrW (bus.regwrite_w),
    .sel (fwdB)
  );

  assign bus.stall_f      = rst_n & stall;
  assign bus.stall_d      = rst_n & stall;
  assign bus.flush_e      = rst_n & stall;
  assign bus.flush_d      = rst_n & flushD;
  assign bus.freeze       = rst_n & frz;
  assign bus.fwd_a_e      = rst_n ? fwdA : FWD_RF;
  assign bus.fwd_b_e      = rst_n ? fwdB : FWD_RF;
  assign bus.stall_cycles = stallCycles;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Scoreboard bench for hazard_sched_ctrl: stimulus pushes reference-model
// expectations into a queue, a negedge monitor pops and compares.
module tb_hazard_sched_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned LUP = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic          rst_n;
    logic [AW-1:0] rs_d, rt_d;
    logic          use_rs_d, use_rt_d, jump_d;
    logic [AW-1:0] rs_e, rt_e, rd_e;
    logic          regwrite_e, memread_e;
    logic [AW-1:0] rd_m1;
    logic          regwrite_m1, memread_m1;
    logic [AW-1:0] rd_m2;
    logic          regwrite_m2;
    logic [AW-1:0] rd_w;
    logic          regwrite_w, dmem_req_m2, dmem_ready;
  } stim_t;

  typedef struct {
    logic          stall_f, stall_d, flush_d, flush_e, freeze;
    logic [1:0]    fa, fb;
    logic [CW-1:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_sched_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  hazard_sched_ctrl #(.REG_AW(AW), .LU_PENALTY(LUP), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: memory-wait flag, count of owed bubbles, stall counter.
  bit mMemWait = 0;
  int mOwed = 0;
  int mCnt = 0;

  function automatic stim_t nop();
    stim_t s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic bit loadHits(input stim_t s, input logic [AW-1:0] rd,
                                  input logic rw, input logic mr);
    return mr && rw && (rd != 0) &&
           ((s.use_rs_d && s.rs_d == rd) || (s.use_rt_d && s.rt_d == rd));
  endfunction

  function automatic logic [1:0] fwdOf(input stim_t s, input logic [AW-1:0] src);
    if (src == 0) return 2'd0;
    if (s.regwrite_m1 && !s.memread_m1 && s.rd_m1 == src) return 2'd1;
    if (s.regwrite_m2 && s.rd_m2 == src) return 2'd2;
    if (s.regwrite_w && s.rd_w == src) return 2'd3;
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit hzE, hzM1, busy;
    @(posedge clk);
    #1;
    rst_n           = s.rst_n;
    bus.rs_d        = s.rs_d;        bus.rt_d        = s.rt_d;
    bus.use_rs_d    = s.use_rs_d;    bus.use_rt_d    = s.use_rt_d;
    bus.jump_d      = s.jump_d;
    bus.rs_e        = s.rs_e;        bus.rt_e        = s.rt_e;
    bus.rd_e        = s.rd_e;        bus.regwrite_e  = s.regwrite_e;
    bus.memread_e   = s.memread_e;
    bus.rd_m1       = s.rd_m1;       bus.regwrite_m1 = s.regwrite_m1;
    bus.memread_m1  = s.memread_m1;
    bus.rd_m2       = s.rd_m2;       bus.regwrite_m2 = s.regwrite_m2;
    bus.rd_w        = s.rd_w;        bus.regwrite_w  = s.regwrite_w;
    bus.dmem_req_m2 = s.dmem_req_m2; bus.dmem_ready  = s.dmem_ready;

    e = '{default: '0};
    e.cyc = CW'(mCnt);
    hzE  = loadHits(s, s.rd_e, s.regwrite_e, s.memread_e);
    hzM1 = loadHits(s, s.rd_m1, s.regwrite_m1, s.memread_m1);
    busy = s.dmem_req_m2 && !s.dmem_ready;
    if (s.rst_n) begin
      if (mMemWait || busy) e.freeze = 1'b1;
      else if (mOwed > 0 || hzE || hzM1) begin
        e.stall_f = 1'b1; e.stall_d = 1'b1; e.flush_e = 1'b1;
      end else if (s.jump_d) e.flush_d = 1'b1;
      e.fa = fwdOf(s, s.rs_e);
      e.fb = fwdOf(s, s.rt_e);
    end
    expQ.push_back(e);

    if (!s.rst_n) begin
      mMemWait = 0; mOwed = 0; mCnt = 0;
    end else begin
      if ((e.freeze || e.stall_d) && mCnt < CNT_MAX) mCnt++;
      if (mMemWait) begin
        if (s.dmem_ready) mMemWait = 0;
      end else if (busy) mMemWait = 1;
      else if (mOwed > 0) mOwed--;
      else if (hzE) mOwed = LUP - 1;
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("stall_f", 8'(bus.stall_f), 8'(e.stall_f));
      check("stall_d", 8'(bus.stall_d), 8'(e.stall_d));
      check("flush_d", 8'(bus.flush_d), 8'(e.flush_d));
      check("flush_e", 8'(bus.flush_e), 8'(e.flush_e));
      check("freeze", 8'(bus.freeze), 8'(e.freeze));
      check("fwd_a_e", 8'(bus.fwd_a_e), 8'(e.fa));
      check("fwd_b_e", 8'(bus.fwd_b_e), 8'(e.fb));
      check("stall_cycles", 8'(bus.stall_cycles), 8'(e.cyc));
    end
  end

  function automatic stim_t randStim();
    stim_t s;
    s.rst_n       = ($urandom_range(0, 199) != 0);
    s.rs_d        = AW'($urandom_range(0, 3));
    s.rt_d        = AW'($urandom_range(0, 3));
    s.use_rs_d    = 1'($urandom);
    s.use_rt_d    = 1'($urandom);
    s.jump_d      = ($urandom_range(0, 3) == 0);
    s.rs_e        = AW'($urandom_range(0, 3));
    s.rt_e        = AW'($urandom_range(0, 3));
    s.rd_e        = AW'($urandom_range(0, 3));
    s.regwrite_e  = 1'($urandom);
    s.memread_e   = ($urandom_range(0, 3) == 0);
    s.rd_m1       = AW'($urandom_range(0, 3));
    s.regwrite_m1 = 1'($urandom);
    s.memread_m1  = ($urandom_range(0, 3) == 0);
    s.rd_m2       = AW'($urandom_range(0, 3));
    s.regwrite_m2 = 1'($urandom);
    s.rd_w        = AW'($urandom_range(0, 3));
    s.regwrite_w  = 1'($urandom);
    s.dmem_req_m2 = ($urandom_range(0, 6) == 0);
    s.dmem_ready  = 1'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    stim_t ld;
    rst_n = 1'b0;
    s = nop();
    s.rst_n = 1'b0;
    step(s);
    step(s);

    // Load in EX feeding ID rs, with a jump held in ID.
    s = nop();
    s.rd_e = 5'd2; s.regwrite_e = 1; s.memread_e = 1;
    s.rs_d = 5'd2; s.use_rs_d = 1; s.jump_d = 1;
    step(s);
    s.rd_e = 0; s.regwrite_e = 0; s.memread_e = 0;
    s.rd_m1 = 5'd2; s.regwrite_m1 = 1; s.memread_m1 = 1;
    step(s);
    s.rd_m1 = 0; s.regwrite_m1 = 0; s.memread_m1 = 0;
    s.rd_m2 = 5'd2; s.regwrite_m2 = 1;
    step(s);
    step(nop());

    // Load in M1 feeding ID rt: one bubble.
    s = nop();
    s.rd_m1 = 5'd2; s.regwrite_m1 = 1; s.memread_m1 = 1;
    s.rt_d = 5'd2; s.use_rt_d = 1; s.rd_e = 5'd7; s.regwrite_e = 1;
    step(s);
    step(nop());

    // Load to $0 never stalls; $0 source never forwards.
    s = nop();
    s.memread_e = 1; s.regwrite_e = 1; s.use_rs_d = 1;
    s.regwrite_m1 = 1; s.regwrite_m2 = 1;
    step(s);

    // Memory busy three cycles, hazard appears mid-wait.
    s = nop();
    s.dmem_req_m2 = 1;
    step(s);
    step(s);
    s.rd_e = 5'd3; s.regwrite_e = 1; s.memread_e = 1; s.rs_d = 5'd3; s.use_rs_d = 1;
    step(s);
    s.dmem_ready = 1;
    step(s);
    s.dmem_req_m2 = 0; s.dmem_ready = 0;
    step(s);
    step(nop());
    step(nop());

    // Forwarding priority with a load in M1.
    s = nop();
    s.rs_e = 5'd5; s.rt_e = 5'd5;
    s.rd_m1 = 5'd5; s.rd_m2 = 5'd5; s.rd_w = 5'd5;
    s.regwrite_m1 = 1; s.regwrite_m2 = 1; s.regwrite_w = 1;
    step(s);
    s.memread_m1 = 1;
    step(s);
    s.regwrite_m2 = 0;
    step(s);

    // Memory busy during LU_STALL, then reset mid-stall.
    ld = nop();
    ld.rd_e = 5'd4; ld.regwrite_e = 1; ld.memread_e = 1; ld.rs_d = 5'd4; ld.use_rs_d = 1;
    step(ld);
    s = nop(); s.dmem_req_m2 = 1;
    step(s);
    s.dmem_ready = 1;
    step(s);
    step(nop());
    step(nop());
    step(ld);
    s = ld; s.rst_n = 0;
    step(s);
    step(nop());

    for (int i = 0; i < 3000; i++) step(randStim());

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
